md_sched: RTL and testbench

Multiply/divide scheduler for the five-stage MIPS core. It accepts an E-stage multiply/divide or HI/LO write and holds the result in flight for a fixed latency. It owns the architectural HI/LO registers and raises the stall request that the hazard unit ORs into the D/E pipeline-register stall. It also honours the exception flush so that a squashed E-stage instruction never reaches HI/LO.

---
 rtl/md_pkg.sv | 35 +++
 rtl/md_sched_if.sv | 26 ++
 rtl/md_alu.sv | 66 ++++++
 rtl/md_sched.sv | 94 +++++++++
 tb/tb_md_sched.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared encodings, latency defaults and state type for the multiply/divide scheduler.
// Optional MADD/MSUB support is enabled by defining MD_MADD_EN.
package md_pkg;

    localparam int unsigned MD_OP_W       = 3;
    localparam int unsigned MD_CNT_W      = 4;
    localparam int unsigned MD_MUL_LAT_DEF = 5;
    localparam int unsigned MD_DIV_LAT_DEF = 10;

    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_MADD  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MSUB  = 3'd5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // Ops that actually start a busy period in this build.
    function automatic logic md_op_valid(input logic [MD_OP_W-1:0] op);
`ifdef MD_MADD_EN
        return (op <= MD_MSUB);
`else
        return (op <= MD_DIVU);
`endif
    endfunction

    function automatic logic md_op_is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_sched_if.sv
// Pipeline-facing signal bundle of the multiply/divide scheduler.
interface md_sched_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hilo_wr;
    logic        hilo_sel;
    logic [31:0] wdata;
    logic        exc_clr;
    logic        d_is_md;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_val, rt_val, hilo_wr, hilo_sel, wdata, exc_clr, d_is_md,
        input  busy, md_stall, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, hilo_wr, hilo_sel, wdata, exc_clr, d_is_md,
        output busy, md_stall, hi, lo
    );
endinterface

// File: rtl/md_alu.sv
// Combinational multiply/divide datapath producing the next HI/LO pair.
// The accumulate adder for MADD/MSUB exists only when MD_MADD_EN is defined.
module md_alu
    import md_pkg::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        rs_val,
    input  logic [31:0]        rt_val,
    input  logic [31:0]        hi,
    input  logic [31:0]        lo,
    output logic [31:0]        hi_next,
    output logic [31:0]        lo_next,
    output logic               div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] div_b;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;

    assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Divisor forced to 1 on zero so the dividers never see x; the result is dropped at commit.
    assign div_zero = (rt_val == 32'd0);
    assign div_b    = div_zero ? 32'd1 : rt_val;

    assign a_mag = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    assign b_mag = div_b[31]  ? (~div_b + 32'd1)  : div_b;
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign q_s   = (rs_val[31] ^ div_b[31]) ? (~q_mag + 32'd1) : q_mag;
    assign r_s   = rs_val[31] ? (~r_mag + 32'd1) : r_mag;
    assign q_u   = rs_val / div_b;
    assign r_u   = rs_val % div_b;

`ifdef MD_MADD_EN
    logic [63:0] acc_add;
    logic [63:0] acc_sub;
    assign acc_add = {hi, lo} + prod_s;
    assign acc_sub = {hi, lo} - prod_s;
`endif

    always_comb begin
        {hi_next, lo_next} = {hi, lo};
        case (op)
            MD_MULT:  {hi_next, lo_next} = prod_s;
            MD_MULTU: {hi_next, lo_next} = prod_u;
            MD_DIV:   {hi_next, lo_next} = {r_s, q_s};
            MD_DIVU:  {hi_next, lo_next} = {r_u, q_u};
`ifdef MD_MADD_EN
            MD_MADD:  {hi_next, lo_next} = acc_add;
            MD_MSUB:  {hi_next, lo_next} = acc_sub;
`endif
            default:  {hi_next, lo_next} = {hi, lo};
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: fixed-latency result hold, architectural HI/LO and MD stall request.
// Build option MD_MADD_EN adds MADD/MSUB (ops 4/5); otherwise those ops are no-ops.
module md_sched
    import md_pkg::*;
#(
    parameter int unsigned MUL_LAT = MD_MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = MD_DIV_LAT_DEF
)(
    input  logic       clk,
    input  logic       reset,
    md_sched_if.slave  md
);

    localparam logic [MD_CNT_W-1:0] MUL_CNT = MD_CNT_W'(MUL_LAT);
    localparam logic [MD_CNT_W-1:0] DIV_CNT = MD_CNT_W'(DIV_LAT);

    md_state_e           state;
    logic [MD_CNT_W-1:0] cnt;
    logic [31:0]         hi_q;
    logic [31:0]         lo_q;
    logic [31:0]         pend_hi;
    logic [31:0]         pend_lo;
    logic                pend_zero;
    logic [31:0]         alu_hi;
    logic [31:0]         alu_lo;
    logic                alu_div_zero;
    logic                accept;
    logic                wr_ok;

    md_alu u_alu (
        .op       (md.op),
        .rs_val   (md.rs_val),
        .rt_val   (md.rt_val),
        .hi       (hi_q),
        .lo       (lo_q),
        .hi_next  (alu_hi),
        .lo_next  (alu_lo),
        .div_zero (alu_div_zero)
    );

    assign accept = md.start & ~md.exc_clr & md_op_valid(md.op);
    assign wr_ok  = md.hilo_wr & ~md.exc_clr;

    // FSM, latency counter, pending result and HI/LO in one register block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pend_hi   <= alu_hi;
                        pend_lo   <= alu_lo;
                        pend_zero <= md_op_is_div(md.op) & alu_div_zero;
                        cnt       <= md_op_is_div(md.op) ? DIV_CNT : MUL_CNT;
                        state     <= RUN;
                    end else if (wr_ok) begin
                        if (md.hilo_sel) hi_q <= md.wdata;
                        else             lo_q <= md.wdata;
                    end
                end
                RUN: begin
                    // Divide-by-zero keeps the full busy time but leaves HI/LO alone.
                    if (cnt == MD_CNT_W'(1)) begin
                        if (!pend_zero) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - MD_CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign md.busy     = (state == RUN);
    assign md.md_stall = md.d_is_md & ((state == RUN) | (md.start & ~md.exc_clr));
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed, table-driven bench for md_sched with hand sequences for multi-cycle corners.
module tb_md_sched;
    logic clk;
    logic reset;

    md_sched_if mif ();

    md_sched u_dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        wr;
        logic        sel;
        logic [31:0] wdata;
        logic        exc;
        int          lat;
        logic        stall;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mif.start    = 1'b0;
        mif.op       = 3'd0;
        mif.rs_val   = 32'd0;
        mif.rt_val   = 32'd0;
        mif.hilo_wr  = 1'b0;
        mif.hilo_sel = 1'b0;
        mif.wdata    = 32'd0;
        mif.exc_clr  = 1'b0;
        mif.d_is_md  = 1'b0;
    endtask

    // Counts busy cycles starting from the current cycle, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (mif.busy && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    int nb;
    int nstall;

    initial begin
        vecs[0]  = '{1'b1, 3'd0, 32'hFFFFFFFE, 32'd3,        1'b0, 1'b0, 32'd0,        1'b0, 5,  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{1'b1, 3'd3, 32'd100,      32'd7,        1'b0, 1'b0, 32'd0,        1'b0, 10, 1'b1, 32'd2,        32'd14};
        vecs[2]  = '{1'b0, 3'd0, 32'd0,        32'd0,        1'b1, 1'b1, 32'h1234,     1'b0, 0,  1'b0, 32'h1234,     32'd14};
        vecs[3]  = '{1'b1, 3'd2, 32'hFFFFFFF9, 32'd0,        1'b0, 1'b0, 32'd0,        1'b0, 10, 1'b1, 32'h1234,     32'd14};
        vecs[4]  = '{1'b1, 3'd1, 32'd5,        32'd5,        1'b0, 1'b0, 32'd0,        1'b1, 0,  1'b0, 32'h1234,     32'd14};
        vecs[5]  = '{1'b1, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0,        1'b0, 5,  1'b1, 32'hFFFFFFFE, 32'h00000001};
        vecs[6]  = '{1'b1, 3'd2, 32'hFFFFFFF9, 32'd2,        1'b0, 1'b0, 32'd0,        1'b0, 10, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[7]  = '{1'b1, 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0,        1'b0, 10, 1'b1, 32'd0,        32'h80000000};
        vecs[8]  = '{1'b1, 3'd2, 32'd7,        32'hFFFFFFFE, 1'b0, 1'b0, 32'd0,        1'b0, 10, 1'b1, 32'd1,        32'hFFFFFFFD};
        vecs[9]  = '{1'b0, 3'd0, 32'd0,        32'd0,        1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 0,  1'b0, 32'd1,        32'hFFFFFFFD};
        vecs[10] = '{1'b0, 3'd0, 32'd0,        32'd0,        1'b1, 1'b1, 32'd0,        1'b0, 0,  1'b0, 32'd0,        32'hFFFFFFFD};
        vecs[11] = '{1'b0, 3'd0, 32'd0,        32'd0,        1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 0,  1'b0, 32'd0,        32'hFFFFFFFF};
        vecs[12] = '{1'b1, 3'd6, 32'd9,        32'd9,        1'b0, 1'b0, 32'd0,        1'b0, 0,  1'b1, 32'd0,        32'hFFFFFFFF};
`ifdef MD_MADD_EN
        vecs[13] = '{1'b1, 3'd4, 32'd1,        32'd1,        1'b0, 1'b0, 32'd0,        1'b0, 5,  1'b1, 32'd1,        32'd0};
        vecs[14] = '{1'b1, 3'd5, 32'd2,        32'd3,        1'b0, 1'b0, 32'd0,        1'b0, 5,  1'b1, 32'd0,        32'hFFFFFFFA};
`else
        vecs[13] = '{1'b1, 3'd4, 32'd1,        32'd1,        1'b0, 1'b0, 32'd0,        1'b0, 0,  1'b1, 32'd0,        32'hFFFFFFFF};
        vecs[14] = '{1'b1, 3'd5, 32'd2,        32'd3,        1'b0, 1'b0, 32'd0,        1'b0, 0,  1'b1, 32'd0,        32'hFFFFFFFF};
`endif

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mif.d_is_md = 1'b1;
        #1;
        chk("reset_busy",  32'(mif.busy), 32'd0);
        chk("reset_stall", 32'(mif.md_stall), 32'd0);
        chk("reset_hi",    mif.hi, 32'd0);
        chk("reset_lo",    mif.lo, 32'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            mif.start    = vecs[i].start;
            mif.op       = vecs[i].op;
            mif.rs_val   = vecs[i].rs;
            mif.rt_val   = vecs[i].rt;
            mif.hilo_wr  = vecs[i].wr;
            mif.hilo_sel = vecs[i].sel;
            mif.wdata    = vecs[i].wdata;
            mif.exc_clr  = vecs[i].exc;
            mif.d_is_md  = 1'b1;
            #1;
            chk($sformatf("v%0d_stall", i), 32'(mif.md_stall), 32'(vecs[i].stall));
            @(posedge clk);
            #1;
            idle_inputs();
            count_busy(nb);
            chk($sformatf("v%0d_lat", i), 32'(nb), 32'(vecs[i].lat));
            chk($sformatf("v%0d_hi", i), mif.hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), mif.lo, vecs[i].lo);
        end

        // DIVU with an MD instruction waiting in D for the whole busy window.
        @(negedge clk);
        mif.start = 1'b1; mif.op = 3'd3; mif.rs_val = 32'd100; mif.rt_val = 32'd7;
        mif.d_is_md = 1'b1;
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        nb = 0;
        nstall = 0;
        while (mif.busy && nb < 40) begin
            nb++;
            if (mif.md_stall) nstall++;
            @(posedge clk);
            #1;
        end
        chk("divu_busy",        32'(nb), 32'd10);
        chk("divu_stall_cyc",   32'(nstall), 32'd10);
        chk("divu_stall_after", 32'(mif.md_stall), 32'd0);
        chk("divu_hi", mif.hi, 32'd2);
        chk("divu_lo", mif.lo, 32'd14);
        idle_inputs();

        // exc_clr and a stray start while RUN: neither aborts nor restarts.
        @(negedge clk);
        mif.start = 1'b1; mif.op = 3'd0; mif.rs_val = 32'd3; mif.rt_val = 32'd4;
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        mif.exc_clr = 1'b1;
        @(negedge clk);
        mif.exc_clr = 1'b0;
        mif.start = 1'b1; mif.op = 3'd3; mif.rs_val = 32'd100; mif.rt_val = 32'd7;
        @(posedge clk);
        #1;
        idle_inputs();
        count_busy(nb);
        chk("run_ignore_busy", 32'(nb + 2), 32'd5);
        chk("run_ignore_hi", mif.hi, 32'd0);
        chk("run_ignore_lo", mif.lo, 32'd12);

        // Reset in cycle T+3 of a MULT discards the pending result.
        @(negedge clk);
        mif.start = 1'b1; mif.op = 3'd0; mif.rs_val = 32'd2; mif.rt_val = 32'd3;
        @(posedge clk);
        #1;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_run_busy", 32'(mif.busy), 32'd0);
        chk("rst_run_hi", mif.hi, 32'd0);
        chk("rst_run_lo", mif.lo, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("rst_run_nocommit_lo", mif.lo, 32'd0);
        chk("rst_run_nocommit_busy", 32'(mif.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
